rv_regfile: RTL and testbench

Parametrised integer register file for the RV32/RV64 pipelines. Provides NREAD registered read ports, one write port with same-cycle write-to-read bypass, and a hardwired-zero x0 option. A built-in clear sequencer zeroes every register after reset or on request, so register contents are deterministic without an async-reset flop array. Sits between decode (read addresses) and writeback (rd), one cycle of read latency.

---
 rtl/rv_regfile.sv | 122 ++++++++++++
 tb/tb_rv_regfile.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_regfile.sv
// rv_regfile: integer register file with NREAD registered read ports, one
// write port with same-cycle write-to-read bypass, and an optional
// hardwired-zero register 0.
//
// The storage array has no reset. After reset, or when clear_in is pulsed,
// a clear sequencer writes zero to every register, one register per cycle.
// While this runs, ready_out is low and the read outputs are held at zero.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | zeroing regs[r_clr_idx] each cycle; writes dropped, reads 0
//   ST_RUN   | normal operation: writes land, reads registered (stallable)
module rv_regfile #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    parameter int  NREAD    = 2,
    parameter bit  ZERO_REG = 1'b1,
    localparam int ADDR_W   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset_n_in,
    input  logic                    stall_in,
    input  logic                    clear_in,
    input  logic [NREAD*ADDR_W-1:0] rs_in,
    input  logic [ADDR_W-1:0]       rd_in,
    input  logic                    rd_write_in,
    input  logic [XLEN-1:0]         rd_value_in,
    output logic [NREAD*XLEN-1:0]   rs_value_out,
    output logic                    ready_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_clr_idx;
    logic [ADDR_W-1:0]       w_clr_idx_nxt;
    logic [XLEN-1:0]         r_regs [NREGS];
    logic [NREAD*XLEN-1:0]   r_rs_value;
    logic [NREAD*XLEN-1:0]   w_rs_value_nxt;
    logic                    w_wr_ok;
    logic                    w_wr_en;

    // A write is meaningful unless it targets the hardwired-zero register;
    // it only lands while running.
    always_comb begin
        w_wr_ok = rd_write_in && !(ZERO_REG && (rd_in == '0));
        w_wr_en = (r_state == ST_RUN) && w_wr_ok;
    end

    // Next-state logic: walk the clear index to the last register, then run.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            ST_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                if (r_clr_idx == ADDR_W'(NREGS - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_in) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // Read data selection. The zero register takes priority over bypass, and
    // bypass takes priority over the array. A stall leaves the previous value.
    always_comb begin
        w_rs_value_nxt = r_rs_value;
        if (r_state == ST_CLEAR) begin
            w_rs_value_nxt = '0;
        end else if (!stall_in) begin
            for (int k = 0; k < NREAD; k++) begin
                if (ZERO_REG && (rs_in[k*ADDR_W +: ADDR_W] == '0)) begin
                    w_rs_value_nxt[k*XLEN +: XLEN] = '0;
                end else if (w_wr_ok && (rd_in == rs_in[k*ADDR_W +: ADDR_W])) begin
                    w_rs_value_nxt[k*XLEN +: XLEN] = rd_value_in;
                end else begin
                    w_rs_value_nxt[k*XLEN +: XLEN] = r_regs[rs_in[k*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    // Control state and registered read outputs.
    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_CLEAR;
            r_clr_idx  <= '0;
            r_rs_value <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_idx  <= w_clr_idx_nxt;
            r_rs_value <= w_rs_value_nxt;
        end
    end

    // Storage array: deliberately unreset; the clear sequencer defines it.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[rd_in] <= rd_value_in;
        end
    end

    assign rs_value_out = r_rs_value;
    assign ready_out    = (r_state == ST_RUN);

endmodule

// File: tb/tb_rv_regfile.sv
// tb_rv_regfile: drives two rv_regfile instances in lockstep.
// dut0 uses the default parameters; dut1 is XLEN=64, NREGS=16, NREAD=3 with
// an ordinary register 0. A per-instance array model predicts the outputs.
module tb_rv_regfile;

    logic        clk = 1'b0;
    logic        reset_n_in;
    logic        stall, clr, we;
    logic [4:0]  rd, rs0, rs1, rs2;
    logic [63:0] val;
    logic [63:0]  out0;
    logic [191:0] out1;
    logic         rdy0, rdy1;

    int checks   = 0;
    int failures = 0;

    int nregs [2] = '{32, 16};
    int nread [2] = '{2, 3};
    bit zr    [2] = '{1'b1, 1'b0};

    logic [63:0] m_regs  [2][32];
    logic [63:0] m_out   [2][3];
    int          m_left  [2];
    bit          m_ready [2];

    always #5 clk = ~clk;

    rv_regfile dut0 (
        .clk          (clk),
        .reset_n_in   (reset_n_in),
        .stall_in     (stall),
        .clear_in     (clr),
        .rs_in        ({rs1, rs0}),
        .rd_in        (rd),
        .rd_write_in  (we),
        .rd_value_in  (val[31:0]),
        .rs_value_out (out0),
        .ready_out    (rdy0)
    );

    rv_regfile #(.XLEN(64), .NREGS(16), .NREAD(3), .ZERO_REG(1'b0)) dut1 (
        .clk          (clk),
        .reset_n_in   (reset_n_in),
        .stall_in     (stall),
        .clear_in     (clr),
        .rs_in        ({rs2[3:0], rs1[3:0], rs0[3:0]}),
        .rd_in        (rd[3:0]),
        .rd_write_in  (we),
        .rd_value_in  (val),
        .rs_value_out (out1),
        .ready_out    (rdy1)
    );

    function automatic logic [63:0] out_of(int i, int k);
        if (i == 0) return {32'h0, out0[k*32 +: 32]};
        return out1[k*64 +: 64];
    endfunction

    function automatic logic rdy_of(int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction

    task automatic assert_reset();
        reset_n_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = 1'b0;
            m_left[i]  = nregs[i];
            for (int k = 0; k < 3; k++) m_out[i][k] = '0;
            for (int r = 0; r < 32; r++) m_regs[i][r] = '0;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n_in = 1'b1;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic s, input logic c, input logic w,
                        input logic [4:0] a, input logic [63:0] v,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2);
        int          ad;
        int          ra [3];
        logic [63:0] vv;
        bit          wok;
        stall = s; clr = c; we = w; rd = a; val = v;
        rs0 = r0; rs1 = r1; rs2 = r2;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            ad    = int'(a)  % nregs[i];
            ra[0] = int'(r0) % nregs[i];
            ra[1] = int'(r1) % nregs[i];
            ra[2] = int'(r2) % nregs[i];
            vv    = (i == 0) ? {32'h0, v[31:0]} : v;
            if (!m_ready[i]) begin
                for (int k = 0; k < 3; k++) m_out[i][k] = '0;
                m_left[i]--;
                if (m_left[i] == 0) m_ready[i] = 1'b1;
            end else begin
                wok = w && !(zr[i] && ad == 0);
                if (!s) begin
                    for (int k = 0; k < nread[i]; k++) begin
                        if (zr[i] && ra[k] == 0)      m_out[i][k] = '0;
                        else if (wok && ad == ra[k])  m_out[i][k] = vv;
                        else                          m_out[i][k] = m_regs[i][ra[k]];
                    end
                end
                if (wok) m_regs[i][ad] = vv;
                if (c) begin
                    m_ready[i] = 1'b0;
                    m_left[i]  = nregs[i];
                    for (int r = 0; r < 32; r++) m_regs[i][r] = '0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, r0, r1, r2);
    endtask

    task automatic test_reset();
        assert_reset();
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%0b exp=0", rdy0); end
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%0b exp=0", rdy1); end
        checks++; if (out0 !== 64'h0) begin failures++; $display("FAIL reset_out0 got=%h exp=0", out0); end
        checks++; if (out1 !== 192'h0) begin failures++; $display("FAIL reset_out1 got=%h exp=0", out1); end
        release_reset();
        for (int n = 1; n <= 32; n++) begin
            idle_read(5'd0, 5'd0, 5'd0);
            checks++; if (rdy0 !== (n >= 32)) begin failures++; $display("FAIL clr_ready0 edge=%0d got=%0b exp=%0b", n, rdy0, n >= 32); end
            checks++; if (rdy1 !== (n >= 16)) begin failures++; $display("FAIL clr_ready1 edge=%0d got=%0b exp=%0b", n, rdy1, n >= 16); end
        end
        for (int r = 0; r < 32; r++) begin
            idle_read(5'(r), 5'(31 - r), 5'(r));
            checks++; if (out0 !== 64'h0) begin failures++; $display("FAIL init_zero0 reg=%0d got=%h exp=0", r, out0); end
            checks++; if (out1 !== 192'h0) begin failures++; $display("FAIL init_zero1 reg=%0d got=%h exp=0", r, out1); end
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b0, 1'b1, 5'd5, 64'hDEADBEEF, 5'd1, 5'd2, 5'd3);
        idle_read(5'd5, 5'd1, 5'd5);
        checks++; if (out_of(0, 0) !== 64'hDEADBEEF) begin failures++; $display("FAIL wr_rd_x5_dut0 got=%h exp=deadbeef", out_of(0, 0)); end
        checks++; if (out_of(1, 0) !== 64'hDEADBEEF) begin failures++; $display("FAIL wr_rd_x5_dut1 got=%h exp=deadbeef", out_of(1, 0)); end
        step(1'b0, 1'b0, 1'b1, 5'd0, 64'h1234, 5'd5, 5'd5, 5'd5);
        idle_read(5'd0, 5'd0, 5'd0);
        checks++; if (out_of(0, 0) !== 64'h0) begin failures++; $display("FAIL x0_zero_dut0 got=%h exp=0", out_of(0, 0)); end
        checks++; if (out_of(1, 0) !== 64'h1234) begin failures++; $display("FAIL x0_plain_dut1 got=%h exp=1234", out_of(1, 0)); end
        // Same-cycle write to x0 must not bypass onto a zero register.
        step(1'b0, 1'b0, 1'b1, 5'd0, 64'h5555, 5'd0, 5'd0, 5'd0);
        checks++; if (out_of(0, 1) !== 64'h0) begin failures++; $display("FAIL x0_bypass_dut0 got=%h exp=0", out_of(0, 1)); end
        checks++; if (out_of(1, 1) !== 64'h5555) begin failures++; $display("FAIL x0_bypass_dut1 got=%h exp=5555", out_of(1, 1)); end
    endtask

    task automatic test_bypass();
        step(1'b0, 1'b0, 1'b1, 5'd7, 64'h1111_2222, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 5'd7, 64'hA5A5A5A5, 5'd7, 5'd7, 5'd7);
        for (int k = 0; k < 2; k++) begin
            checks++; if (out_of(0, k) !== 64'hA5A5A5A5) begin failures++; $display("FAIL bypass_dut0 port=%0d got=%h exp=a5a5a5a5", k, out_of(0, k)); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_of(1, k) !== 64'hA5A5A5A5) begin failures++; $display("FAIL bypass_dut1 port=%0d got=%h exp=a5a5a5a5", k, out_of(1, k)); end
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 1'b1, 5'd3, 64'h11, 5'd0, 5'd0, 5'd0);
        idle_read(5'd3, 5'd3, 5'd3);
        checks++; if (out_of(0, 0) !== 64'h11) begin failures++; $display("FAIL stall_pre got=%h exp=11", out_of(0, 0)); end
        for (int n = 0; n < 2; n++) begin
            step(1'b1, 1'b0, 1'b1, 5'd3, 64'h22, 5'd3, 5'd3, 5'd3);
            checks++; if (out_of(0, 0) !== 64'h11) begin failures++; $display("FAIL stall_hold_dut0 cyc=%0d got=%h exp=11", n, out_of(0, 0)); end
            checks++; if (out_of(1, 2) !== 64'h11) begin failures++; $display("FAIL stall_hold_dut1 cyc=%0d got=%h exp=11", n, out_of(1, 2)); end
        end
        idle_read(5'd3, 5'd3, 5'd3);
        checks++; if (out_of(0, 0) !== 64'h22) begin failures++; $display("FAIL stall_release_dut0 got=%h exp=22", out_of(0, 0)); end
        checks++; if (out_of(1, 2) !== 64'h22) begin failures++; $display("FAIL stall_release_dut1 got=%h exp=22", out_of(1, 2)); end
    endtask

    task automatic test_clear();
        for (int r = 1; r < 32; r++) step(1'b0, 1'b0, 1'b1, 5'(r), {$urandom, $urandom} | 64'h1, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b1, 1'b1, 5'd9, 64'h99, 5'd9, 5'd9, 5'd9);
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL clear_start_ready0 got=%0b exp=0", rdy0); end
        for (int j = 1; j <= 32; j++) begin
            step(1'b0, 1'b0, 1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            checks++; if (rdy0 !== (j >= 32)) begin failures++; $display("FAIL clear_ready0 edge=%0d got=%0b exp=%0b", j, rdy0, j >= 32); end
            checks++; if (out0 !== 64'h0) begin failures++; $display("FAIL clear_out0 edge=%0d got=%h exp=0", j, out0); end
            checks++; if (rdy1 !== m_ready[1]) begin failures++; $display("FAIL clear_ready1 edge=%0d got=%0b exp=%0b", j, rdy1, m_ready[1]); end
        end
        for (int r = 0; r < 32; r++) begin
            idle_read(5'(r), 5'(r ^ 5'd31), 5'(r));
            checks++; if (out0 !== 64'h0) begin failures++; $display("FAIL after_clear0 reg=%0d got=%h exp=0", r, out0); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (out_of(1, k) !== m_out[1][k]) begin failures++; $display("FAIL after_clear1 reg=%0d port=%0d got=%h exp=%h", r, k, out_of(1, k), m_out[1][k]); end
            end
        end
        step(1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0);
        for (int j = 0; j < 10; j++) idle_read(5'd0, 5'd0, 5'd0);
        assert_reset();
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL midclear_reset_ready0 got=%0b exp=0", rdy0); end
        release_reset();
        for (int j = 1; j <= 32; j++) begin
            idle_read(5'd0, 5'd0, 5'd0);
            checks++; if (rdy0 !== (j >= 32)) begin failures++; $display("FAIL restart_ready0 edge=%0d got=%0b exp=%0b", j, rdy0, j >= 32); end
        end
    endtask

    task automatic test_wide();
        step(1'b0, 1'b0, 1'b1, 5'd15, 64'hFFFF_FFFF_0000_0001, 5'd0, 5'd0, 5'd0);
        idle_read(5'd15, 5'd15, 5'd15);
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_of(1, k) !== 64'hFFFF_FFFF_0000_0001) begin failures++; $display("FAIL wide_x15 port=%0d got=%h exp=ffffffff00000001", k, out_of(1, k)); end
        end
        checks++; if (out_of(0, 1) !== 64'h1) begin failures++; $display("FAIL narrow_x15 got=%h exp=1", out_of(0, 1)); end
    endtask

    task automatic test_random();
        logic [4:0] a, r0, r1, r2;
        for (int n = 0; n < 600; n++) begin
            r0 = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                 a, {$urandom, $urandom}, r0, r1, r2);
            for (int i = 0; i < 2; i++) begin
                checks++; if (rdy_of(i) !== m_ready[i]) begin failures++; $display("FAIL rand_ready dut%0d cyc=%0d got=%0b exp=%0b", i, n, rdy_of(i), m_ready[i]); end
                for (int k = 0; k < nread[i]; k++) begin
                    checks++; if (out_of(i, k) !== m_out[i][k]) begin failures++; $display("FAIL rand_read dut%0d cyc=%0d port=%0d got=%h exp=%h", i, n, k, out_of(i, k), m_out[i][k]); end
                end
            end
        end
        step(1'b0, 1'b0, 1'b1, 5'd1, 64'hCAFE_F00D, 5'd1, 5'd1, 5'd1);
        assert_reset();
        checks++; if (out0 !== 64'h0) begin failures++; $display("FAIL async_reset_out0 got=%h exp=0", out0); end
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL async_reset_ready1 got=%0b exp=0", rdy1); end
        release_reset();
    endtask

    initial begin
        reset_n_in = 1'b0;
        stall = 1'b0; clr = 1'b0; we = 1'b0;
        rd = '0; rs0 = '0; rs1 = '0; rs2 = '0; val = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_clear();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
